// File: rtl/keccak_round_ctrl_if.sv
// rtl/keccak_round_ctrl_if.sv - state-in / permuted-state-out handshake bundle
// for keccak_round_ctrl.
interface keccak_round_ctrl_if #(
  parameter int STATE_W = 1600
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [STATE_W-1:0] state_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [STATE_W-1:0] state_o;

  modport slave (
    input  in_valid_i,
    input  state_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output state_o
  );

  modport master (
    output in_valid_i,
    output state_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  state_o
  );
endinterface

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - Keccak-f[1600] round sequencer around an external
// combinational round datapath.
package keccak_pkg;
  localparam int LANE_SIZE        = 64;
  localparam int MAX_ROUNDS       = 24;
  localparam int ROUND_INDEX_SIZE = 5;
  localparam int STATE_SIZE       = 25 * LANE_SIZE;
endpackage

module keccak_round_ctrl
  import keccak_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  keccak_round_ctrl_if.slave          io,
  output logic [STATE_SIZE-1:0]       rnd_state_o,
  output logic [ROUND_INDEX_SIZE-1:0] round_index_o,
  input  logic [STATE_SIZE-1:0]       rnd_state_i,
  output logic                        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [ROUND_INDEX_SIZE-1:0] LAST_ROUND = ROUND_INDEX_SIZE'(MAX_ROUNDS - 1);

  fsm_e                        fsm_q, fsm_d;
  logic [STATE_SIZE-1:0]       state_q, state_d;
  logic [ROUND_INDEX_SIZE-1:0] round_q, round_d;
  logic                        in_ready;

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    round_d  = round_q;
    in_ready = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (io.in_valid_i) begin
          state_d = io.state_i;
          round_d = '0;
          fsm_d   = RUN;
        end
      end

      RUN: begin
        state_d = rnd_state_i;
        if (round_q < LAST_ROUND) begin
          round_d = round_q + ROUND_INDEX_SIZE'(1);
        end else begin
          round_d = '0;
          fsm_d   = DONE;
        end
      end

      DONE: begin
        // Draining the result and loading the next job share one edge.
        in_ready = io.out_ready_i;
        if (io.out_ready_i) begin
          if (io.in_valid_i) begin
            state_d = io.state_i;
            round_d = '0;
            fsm_d   = RUN;
          end else begin
            fsm_d = IDLE;
          end
        end
      end

      default: begin
        fsm_d   = IDLE;
        round_d = '0;
      end
    endcase

    if (rst_i) begin
      in_ready = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  assign io.in_ready_o  = in_ready;
  assign io.out_valid_o = (fsm_q == DONE);
  assign io.state_o     = state_q;
  assign rnd_state_o    = state_q;
  assign round_index_o  = (fsm_q == RUN) ? round_q : '0;
  assign busy_o         = (fsm_q == RUN);

  round_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
    round_q <= LAST_ROUND);

  done_holds_state_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (fsm_q == DONE && !io.out_ready_i) |=> (fsm_q == DONE && $stable(state_q)));

endmodule
